cache_tag_ram_nway: RTL
=======================

// Module: cache_tag_ram_nway
// PURPOSE
//  - Parametrised N-way tag store for I/D caches; single-clock successor to the 1W1R tag SRAM model.
//  - Holds a tag and a valid bit per (index, way) and compares the stored tags against a lookup tag.
//  - Returns hit, hit_way and the raw tags one cycle after a lookup.
//  - Provides a reset/flush invalidate sweep and write-first bypass. Sits between the cache controller and the miss/refill path.
// PARAMETERS
//  TAG_WIDTH    20  tag bits per way
//  INDEX_WIDTH  8   set index bits; DEPTH = 1<<INDEX_WIDTH sets
//  WAYS         2   associativity, 1..8
//  WAY_WIDTH    ($clog2(WAYS)>0 ? $clog2(WAYS) : 1)  way-select width (derived, not overridden)
// PORTS
//  clk        in   1                clock, all logic on posedge
//  rst_n      in   1                synchronous active-low reset
//  flush_req  in   1                pulse: invalidate all sets
//  busy       out  1                sweep in progress; lookups and writes ignored
//  rd_en      in   1                lookup request
//  rd_index   in   INDEX_WIDTH      lookup set
//  rd_tag     in   TAG_WIDTH        tag to compare
//  rd_vld     out  1                response strobe (1 cycle after accepted rd_en)
//  hit        out  1                any valid way matched
//  hit_way    out  WAY_WIDTH        lowest matching way
//  multi_hit  out  1                >1 way matched (controller error)
//  rd_tags    out  WAYS*TAG_WIDTH   stored tags, way0 in LSBs
//  rd_valids  out  WAYS             stored valid bits
//  wr_en      in   1                write one way
//  wr_index   in   INDEX_WIDTH      write set
//  wr_way     in   WAY_WIDTH        write way
//  wr_tag     in   TAG_WIDTH        tag written
//  wr_valid   in   1                valid bit written (0 = single-line invalidate)
//  par_err    out  1                parity mismatch on response (PARITY_EN only, else tied 0)
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): all outputs 0. The FSM enters SWEEP with sweep_idx=0. Tag contents are undefined; valid bits are cleared by the sweep.
//  - FSM states:
//    - SWEEP: busy=1. Each cycle clears valid for every way at sweep_idx, then sweep_idx++.
//    - SWEEP exit: after sweep_idx reaches DEPTH-1 the FSM goes to IDLE. A sweep lasts exactly DEPTH cycles.
//    - IDLE: busy=0. flush_req=1 -> SWEEP with sweep_idx=0 on the next cycle.
//    - flush_req while in SWEEP is ignored (does not restart).
//  - While busy=1: rd_en and wr_en are dropped, with no response and no write. rd_vld stays 0.
//  - Lookup: rd_en accepted at cycle N gives rd_vld=1 at cycle N+1 with hit/hit_way/multi_hit/rd_tags/rd_valids. These outputs hold until the next accepted lookup. rd_vld is a 1-cycle pulse.
//  - Match for way w: valid[w] && tag[w]==rd_tag, compared in cycle N+1 against the rd_tag registered at N.
//  - hit_way = lowest matching w; 0 when hit=0. multi_hit = popcount(match)>1.
//  - Write: wr_en at cycle N updates (wr_index, wr_way) at posedge N. Other ways are untouched.
//  - Simultaneous rd/wr to the same index in the same cycle is write-first. The response reflects the new tag/valid for wr_way and the old contents for the other ways.
//  - Index wrap: sweep_idx counter is INDEX_WIDTH+1 bits; the terminal compare is on DEPTH-1, with no wrap to 0 in SWEEP.
//  - rst_n asserted mid-sweep or mid-lookup: pending response discarded (rd_vld=0) and the sweep restarts at 0.
//  - Tag array is inferable as WAYS*DEPTH registers or an SRAM macro. Valid bits are separate flops so the sweep can clear a whole set per cycle.
// CONFIGURATION
//  PARITY_EN defined:
//  - One even-parity bit is stored per way over {wr_valid, wr_tag} on write.
//  - The sweep writes parity consistent with valid=0.
//  - On a response, any way whose parity mismatches forces its match to 0 and sets par_err=1 for that rd_vld cycle.
//  PARITY_EN undefined: no parity storage; par_err tied 0.
// TESTING
//  - Reset: rst_n=0 for 2 cycles, then 1 -> busy=1 for exactly 256 cycles. After that, a lookup at any index gives hit=0 and rd_valids=0.
//  - Write idx 0x3C way1 tag 0xABCDE v=1, then lookup idx 0x3C tag 0xABCDE -> rd_vld next cycle, hit=1, hit_way=1, multi_hit=0.
//  - Same-cycle wr idx 0x10 way0 tag 0x12345 and rd idx 0x10 tag 0x12345 -> hit=1, hit_way=0 (bypass).
//  - Write tag 0x00F0F to both ways of idx 0x80, then lookup -> hit=1, hit_way=0, multi_hit=1. Then wr_valid=0 way0 and lookup again -> hit_way=1, multi_hit=0.
//  - flush_req after filling idx 0..3 -> busy 256 cycles, and rd_en during busy gives no rd_vld. Then lookups return hit=0. flush_req mid-sweep -> length unchanged.
//  - PARITY_EN: force a flip of stored tag bit 0 at idx 5 way0, then lookup -> par_err=1, hit=0.

Source files
------------

// File: rtl/cache_tag_ram_nway.sv
// -----------------------------------------------------------------------------
// cache_tag_ram_nway
//
// Purpose:
//   N-way set-associative tag store for instruction/data caches. For every
//   (set index, way) it holds a tag and a valid bit, and compares the stored
//   tags of one set against a lookup tag. The response (hit, lowest hitting
//   way, multi-hit flag, raw tags and valid bits) appears one cycle after the
//   lookup is accepted. A sweep state machine invalidates every set after
//   reset or on a flush request. A write and a lookup to the same set in the
//   same cycle are write-first: the lookup sees the newly written way.
//
// Optional feature macro:
//   PARITY_EN - stores one even-parity bit per way over {valid, tag}. A way
//               whose parity does not check is forced to miss and raises
//               par_err on the response cycle. Without the macro par_err is 0.
//
// Handshake: rd_en/wr_en/flush_req are sampled on posedge clk. While busy=1
//   (sweep running) rd_en and wr_en are ignored and produce no response and
//   no write. An accepted rd_en in cycle N yields a one-cycle rd_vld pulse in
//   cycle N+1; hit/hit_way/multi_hit/rd_tags/rd_valids hold until the next
//   accepted lookup.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   flush_req           pulse: invalidate all sets (ignored while sweeping)
//   busy                sweep in progress
//   rd_en/rd_index/rd_tag                  lookup request
//   rd_vld/hit/hit_way/multi_hit           lookup response
//   rd_tags/rd_valids                      stored tags (way0 in LSBs) / valids
//   wr_en/wr_index/wr_way/wr_tag/wr_valid  single-way write
//   par_err             parity error on the response cycle
// -----------------------------------------------------------------------------
module cache_tag_ram_nway #(
  parameter int  TAG_WIDTH   = 20,
  parameter int  INDEX_WIDTH = 8,
  parameter int  WAYS        = 2,
  localparam int WAY_WIDTH   = ($clog2(WAYS) > 0) ? $clog2(WAYS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush_req,
  output logic                      busy,
  input  logic                      rd_en,
  input  logic [INDEX_WIDTH-1:0]    rd_index,
  input  logic [TAG_WIDTH-1:0]      rd_tag,
  output logic                      rd_vld,
  output logic                      hit,
  output logic [WAY_WIDTH-1:0]      hit_way,
  output logic                      multi_hit,
  output logic [WAYS*TAG_WIDTH-1:0] rd_tags,
  output logic [WAYS-1:0]           rd_valids,
  input  logic                      wr_en,
  input  logic [INDEX_WIDTH-1:0]    wr_index,
  input  logic [WAY_WIDTH-1:0]      wr_way,
  input  logic [TAG_WIDTH-1:0]      wr_tag,
  input  logic                      wr_valid,
  output logic                      par_err
);

  localparam int DEPTH = 1 << INDEX_WIDTH;
  // The sweep counter is one bit wider than the index so the terminal
  // compare never relies on a wrap back to zero.
  localparam logic [INDEX_WIDTH:0] LAST_IDX = (INDEX_WIDTH+1)'(DEPTH - 1);
  localparam logic [INDEX_WIDTH:0] IDX_ONE  = (INDEX_WIDTH+1)'(1);

  // ---------------------------------------------------------------------------
  // Sweep FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [0:0] {
    ST_SWEEP = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [INDEX_WIDTH:0]   sweep_idx;
  logic [INDEX_WIDTH:0]   sweep_idx_nxt;
  logic [INDEX_WIDTH-1:0] sweep_set;
  logic                   sweeping;
  logic                   rd_acc;
  logic                   wr_acc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_SWEEP;
      sweep_idx <= '0;
    end else begin
      state     <= state_nxt;
      sweep_idx <= sweep_idx_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    sweep_idx_nxt = sweep_idx;
    case (state)
      ST_SWEEP: begin
        // flush_req is deliberately not looked at here: a flush during a
        // sweep does not restart it.
        if (sweep_idx == LAST_IDX) begin
          state_nxt     = ST_IDLE;
          sweep_idx_nxt = '0;
        end else begin
          sweep_idx_nxt = sweep_idx + IDX_ONE;
        end
      end
      ST_IDLE: begin
        if (flush_req) begin
          state_nxt     = ST_SWEEP;
          sweep_idx_nxt = '0;
        end
      end
      default: begin
        state_nxt     = ST_SWEEP;
        sweep_idx_nxt = '0;
      end
    endcase
  end

  assign sweeping  = (state == ST_SWEEP);
  assign sweep_set = sweep_idx[INDEX_WIDTH-1:0];
  assign busy      = sweeping;
  assign rd_acc    = rd_en & rst_n & ~sweeping;
  assign wr_acc    = wr_en & rst_n & ~sweeping;

  // ---------------------------------------------------------------------------
  // Storage. Tags have no reset (SRAM-friendly); valid bits are a separate
  // flop array so the sweep can clear a whole set in one cycle.
  // ---------------------------------------------------------------------------
  logic [TAG_WIDTH-1:0] tag_mem   [WAYS][DEPTH];
  logic [WAYS-1:0]      valid_mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int w = 0; w < WAYS; w++) begin
      if (wr_acc && (wr_way == WAY_WIDTH'(w))) begin
        tag_mem[w][wr_index] <= wr_tag;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (sweeping) begin
        valid_mem[sweep_set] <= '0;
      end else begin
        for (int w = 0; w < WAYS; w++) begin
          if (wr_acc && (wr_way == WAY_WIDTH'(w))) begin
            valid_mem[wr_index][w] <= wr_valid;
          end
        end
      end
    end
  end

`ifdef PARITY_EN
  logic par_mem [WAYS][DEPTH];

  // The sweep leaves the tag in place and writes the parity of {0, tag},
  // which is what a later check of an invalid way expects.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (sweeping) begin
        for (int w = 0; w < WAYS; w++) begin
          par_mem[w][sweep_set] <= ^tag_mem[w][sweep_set];
        end
      end else begin
        for (int w = 0; w < WAYS; w++) begin
          if (wr_acc && (wr_way == WAY_WIDTH'(w))) begin
            par_mem[w][wr_index] <= ^{wr_valid, wr_tag};
          end
        end
      end
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Set read with write-first bypass for the way being written this cycle.
  // ---------------------------------------------------------------------------
  logic [WAYS*TAG_WIDTH-1:0] set_tags;
  logic [WAYS-1:0]           set_valids;
`ifdef PARITY_EN
  logic [WAYS-1:0]           set_par;
`endif

  always_comb begin
    set_tags   = '0;
    set_valids = '0;
`ifdef PARITY_EN
    set_par    = '0;
`endif
    for (int w = 0; w < WAYS; w++) begin
      set_tags[w*TAG_WIDTH +: TAG_WIDTH] = tag_mem[w][rd_index];
      set_valids[w]                      = valid_mem[rd_index][w];
`ifdef PARITY_EN
      set_par[w]                         = par_mem[w][rd_index];
`endif
      if (wr_acc && (wr_index == rd_index) && (wr_way == WAY_WIDTH'(w))) begin
        set_tags[w*TAG_WIDTH +: TAG_WIDTH] = wr_tag;
        set_valids[w]                      = wr_valid;
`ifdef PARITY_EN
        set_par[w]                         = ^{wr_valid, wr_tag};
`endif
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Response registers: captured only on an accepted lookup so the outputs
  // hold until the next one.
  // ---------------------------------------------------------------------------
  logic                      rd_vld_q;
  logic [WAYS*TAG_WIDTH-1:0] resp_tags;
  logic [WAYS-1:0]           resp_valids;
  logic [TAG_WIDTH-1:0]      resp_key;
`ifdef PARITY_EN
  logic [WAYS-1:0]           resp_par;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_vld_q    <= 1'b0;
      resp_tags   <= '0;
      resp_valids <= '0;
      resp_key    <= '0;
`ifdef PARITY_EN
      resp_par    <= '0;
`endif
    end else begin
      rd_vld_q <= rd_acc;
      if (rd_acc) begin
        resp_tags   <= set_tags;
        resp_valids <= set_valids;
        resp_key    <= rd_tag;
`ifdef PARITY_EN
        resp_par    <= set_par;
`endif
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Compare, priority select and match count on the registered set.
  // ---------------------------------------------------------------------------
  logic [WAYS-1:0]      match;
  logic [WAYS-1:0]      par_bad;
  logic [WAY_WIDTH-1:0] hit_way_c;
  int                   hit_cnt;

  always_comb begin
    match     = '0;
    par_bad   = '0;
    hit_way_c = '0;
    hit_cnt   = 0;
    for (int w = 0; w < WAYS; w++) begin
`ifdef PARITY_EN
      par_bad[w] = resp_par[w] != ^{resp_valids[w], resp_tags[w*TAG_WIDTH +: TAG_WIDTH]};
`endif
      match[w] = resp_valids[w] && !par_bad[w] &&
                 (resp_tags[w*TAG_WIDTH +: TAG_WIDTH] == resp_key);
    end
    // Walk downwards so the lowest matching way wins.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (match[w]) hit_way_c = WAY_WIDTH'(w);
    end
    for (int w = 0; w < WAYS; w++) begin
      hit_cnt = hit_cnt + (match[w] ? 1 : 0);
    end
  end

  assign rd_vld    = rd_vld_q;
  assign hit       = |match;
  assign hit_way   = hit_way_c;
  assign multi_hit = (hit_cnt > 1);
  assign rd_tags   = resp_tags;
  assign rd_valids = resp_valids;

`ifdef PARITY_EN
  assign par_err = rd_vld_q & (|par_bad);
`else
  assign par_err = 1'b0;
`endif

endmodule
